// File: rtl/vga_clock_pkg.sv
// Shared definitions for the clock core and its button conditioning.
// Contents:
//   ADJ_HRS/ADJ_MIN/ADJ_SEC : channel index of each adjust button
//   *_DEFAULT               : default tick timing
//   adj_state_e             : per-channel adjust FSM encoding
//   width_for()             : bit width needed to hold a given value
package vga_clock_pkg;

    localparam int ADJ_HRS = 0;
    localparam int ADJ_MIN = 1;
    localparam int ADJ_SEC = 2;
    localparam int NUM_ADJ = 3;

    localparam int TICK_DIV_DEFAULT        = 31500;
    localparam int DB_TICKS_DEFAULT        = 10;
    localparam int RPT_DELAY_TICKS_DEFAULT = 500;
    localparam int RPT_TICKS_DEFAULT       = 150;

    typedef enum logic [1:0] {
        ADJ_IDLE   = 2'd0,
        ADJ_HOLD   = 2'd1,
        ADJ_REPEAT = 2'd2
    } adj_state_e;

    // Bits needed to represent the value max_val (at least 1).
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adj_btn_channel.sv
// One button channel: two-flop synchroniser, tick-based debounce, and the
// IDLE/HOLD/REPEAT adjust FSM with its saturating repeat counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : shared one-cycle timebase strobe
//   btn_raw    : asynchronous button level
//   btn_level  : debounced level (registered)
//   adj_pulse  : one-cycle adjust strobe (registered)
module adj_btn_channel
    import vga_clock_pkg::*;
#(
    parameter int DB_TICKS        = DB_TICKS_DEFAULT,
    parameter int RPT_DELAY_TICKS = RPT_DELAY_TICKS_DEFAULT,
    parameter int RPT_TICKS       = RPT_TICKS_DEFAULT,
    parameter bit RPT_EN          = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic adj_pulse
);

    localparam int DB_W    = width_for(DB_TICKS - 1);
    localparam int RPT_MAX = (RPT_DELAY_TICKS > RPT_TICKS) ? RPT_DELAY_TICKS : RPT_TICKS;
    localparam int RPT_W   = width_for(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_TICKS - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY_TICKS - 1);
    localparam logic [RPT_W-1:0] REPEAT_LAST = RPT_W'(RPT_TICKS - 1);
    localparam logic [RPT_W-1:0] RPT_SAT     = '1;

    logic             meta_q, sync_q;
    logic             level_q, level_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    adj_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             pulse_q, pulse_d;
    logic             rise, fall;
    logic [RPT_W-1:0] rpt_inc;

    // Debounce: the new level must be seen on DB_TICKS consecutive ticks.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (sync_q == level_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // FSM works from level_d so the press pulse lands in the same cycle
    // that btn_level rises.
    always_comb begin
        rise    = level_d & ~level_q;
        fall    = ~level_d & level_q;
        rpt_inc = (rpt_cnt_q == RPT_SAT) ? rpt_cnt_q : rpt_cnt_q + 1'b1;

        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 1'b0;

        // Release wins over any repeat due in the same cycle.
        if (fall) begin
            state_d   = ADJ_IDLE;
            rpt_cnt_d = '0;
        end else begin
            unique case (state_q)
                ADJ_IDLE: begin
                    if (rise) begin
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = ADJ_HOLD;
                    end
                end
                ADJ_HOLD: begin
                    if (tick) begin
                        if (RPT_EN && rpt_cnt_q == DELAY_LAST) begin
                            pulse_d   = 1'b1;
                            rpt_cnt_d = '0;
                            state_d   = ADJ_REPEAT;
                        end else begin
                            rpt_cnt_d = rpt_inc;
                        end
                    end
                end
                ADJ_REPEAT: begin
                    if (tick) begin
                        if (rpt_cnt_q == REPEAT_LAST) begin
                            pulse_d   = 1'b1;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_inc;
                        end
                    end
                end
                default: state_d = ADJ_IDLE;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= ADJ_IDLE;
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            meta_q    <= btn_raw;
            sync_q    <= meta_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign btn_level = level_q;
    assign adj_pulse = pulse_q;

endmodule

// File: rtl/adj_button_conditioner.sv
// Button conditioning for the clock core's hour/minute/second adjust inputs.
// A shared prescaler produces a one-cycle tick every TICK_DIV clocks; each
// channel synchronises, debounces and turns its button into adjust pulses
// with optional auto-repeat.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : asynchronous active-high buttons (bit 0 hrs, 1 min, 2 sec)
//   btn_level  : debounced levels (registered)
//   adj_pulse  : one-cycle adjust strobes (registered)
module adj_button_conditioner
    import vga_clock_pkg::*;
#(
    parameter int                   NUM_BTN         = NUM_ADJ,
    parameter int                   TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int                   DB_TICKS        = DB_TICKS_DEFAULT,
    parameter int                   RPT_DELAY_TICKS = RPT_DELAY_TICKS_DEFAULT,
    parameter int                   RPT_TICKS       = RPT_TICKS_DEFAULT,
    parameter logic [NUM_BTN-1:0]   RPT_MASK        = {NUM_BTN{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] adj_pulse
);

    localparam int                TICK_W    = width_for(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        adj_btn_channel #(
            .DB_TICKS        (DB_TICKS),
            .RPT_DELAY_TICKS (RPT_DELAY_TICKS),
            .RPT_TICKS       (RPT_TICKS),
            .RPT_EN          (RPT_MASK[i])
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .btn_raw   (btn_raw[i]),
            .btn_level (btn_level[i]),
            .adj_pulse (adj_pulse[i])
        );
    end

endmodule

// File: tb/tb_adj_button_conditioner.sv
// Directed bench for adj_button_conditioner with TICK_DIV=4, DB_TICKS=2,
// RPT_DELAY_TICKS=8, RPT_TICKS=4. dut_a repeats on all channels; dut_b has
// repeat disabled on channel 2. Both share clock, reset and buttons.
module tb_adj_button_conditioner;

    localparam int NB = 3;
    localparam int MAXP = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] lvl_a, pulse_a, lvl_b, pulse_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor state for dut_a (pulse times, latest level rise) and dut_b (pulse counts).
    int       ptime [NB][MAXP];
    int       pcnt [NB];
    int       rise_last [NB];
    int       cnt_b [NB];
    logic [NB-1:0] lvl_prev_a = '0;

    adj_button_conditioner #(
        .NUM_BTN(NB), .TICK_DIV(4), .DB_TICKS(2), .RPT_DELAY_TICKS(8), .RPT_TICKS(4),
        .RPT_MASK(3'b111)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(lvl_a), .adj_pulse(pulse_a)
    );

    adj_button_conditioner #(
        .NUM_BTN(NB), .TICK_DIV(4), .DB_TICKS(2), .RPT_DELAY_TICKS(8), .RPT_TICKS(4),
        .RPT_MASK(3'b011)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(lvl_b), .adj_pulse(pulse_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int c = 0; c < NB; c++) begin
            if (pulse_a[c] === 1'b1) begin
                if (pcnt[c] < MAXP) ptime[c][pcnt[c]] <= cyc;
                pcnt[c] <= pcnt[c] + 1;
            end
            if (lvl_a[c] === 1'b1 && lvl_prev_a[c] !== 1'b1) rise_last[c] <= cyc;
            if (pulse_b[c] === 1'b1) cnt_b[c] <= cnt_b[c] + 1;
        end
        lvl_prev_a <= lvl_a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = '0;
        wait_cycles(3);
        checks++;
        if (lvl_a !== 3'b000 || pulse_a !== 3'b000) begin
            failures++;
            $display("FAIL reset_a: level=%b pulse=%b expected 000/000", lvl_a, pulse_a);
        end
        checks++;
        if (lvl_b !== 3'b000 || pulse_b !== 3'b000) begin
            failures++;
            $display("FAIL reset_b: level=%b pulse=%b expected 000/000", lvl_b, pulse_b);
        end
        rst_n = 1'b1;
        wait_cycles(20);
        checks++;
        if (pcnt[0] + pcnt[1] + pcnt[2] + cnt_b[0] + cnt_b[1] + cnt_b[2] !== 0) begin
            failures++;
            $display("FAIL idle_no_pulse: pulses=%0d expected 0",
                     pcnt[0] + pcnt[1] + pcnt[2] + cnt_b[0] + cnt_b[1] + cnt_b[2]);
        end
    endtask

    task automatic test_clean_press();
        int n0, t0, tp, lat;
        @(negedge clk);
        n0 = pcnt[0];
        btn_raw[0] = 1'b1;
        t0 = cyc;
        wait_cycles(20);
        btn_raw[0] = 1'b0;
        wait_cycles(20);
        checks++;
        if (pcnt[0] - n0 !== 1) begin
            failures++;
            $display("FAIL clean_count: pulses=%0d expected 1", pcnt[0] - n0);
        end
        tp  = (pcnt[0] - n0 >= 1) ? ptime[0][n0] : -1;
        lat = (tp >= 0) ? tp - t0 : -1;
        checks++;
        if (lat < 7 || lat > 10) begin
            failures++;
            $display("FAIL clean_latency: latency=%0d expected 7..10", lat);
        end
        checks++;
        if (rise_last[0] !== tp) begin
            failures++;
            $display("FAIL clean_level_align: level rise cycle=%0d expected pulse cycle %0d", rise_last[0], tp);
        end
        checks++;
        if (lvl_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL clean_release_level: level=%b expected 0", lvl_a[0]);
        end
    endtask

    task automatic test_bounce();
        int n1, t0, lat;
        @(negedge clk);
        n1 = pcnt[1];
        for (int seg = 0; seg < 10; seg++) begin
            btn_raw[1] = (seg % 2 == 0);
            wait_cycles(3);
        end
        checks++;
        if (pcnt[1] - n1 !== 0 || lvl_a[1] !== 1'b0) begin
            failures++;
            $display("FAIL bounce_quiet: pulses=%0d level=%b expected 0/0", pcnt[1] - n1, lvl_a[1]);
        end
        btn_raw[1] = 1'b1;
        t0 = cyc;
        wait_cycles(20);
        checks++;
        if (pcnt[1] - n1 !== 1) begin
            failures++;
            $display("FAIL bounce_count: pulses=%0d expected 1", pcnt[1] - n1);
        end
        lat = (pcnt[1] - n1 >= 1) ? ptime[1][n1] - t0 : -1;
        checks++;
        if (lat < 6 || lat > 10) begin
            failures++;
            $display("FAIL bounce_latency: latency=%0d expected 6..10", lat);
        end
        btn_raw[1] = 1'b0;
        wait_cycles(20);
    endtask

    task automatic test_hold_repeat();
        int n0, cnt, first_gap, bad;
        @(negedge clk);
        n0 = pcnt[0];
        btn_raw[0] = 1'b1;
        wait_cycles(200);
        btn_raw[0] = 1'b0;
        wait_cycles(20);
        cnt = pcnt[0] - n0;
        // Press + repeats at +32, +48, ... strictly before the release lands at +200.
        checks++;
        if (cnt !== 12) begin
            failures++;
            $display("FAIL hold_count: pulses=%0d expected 12", cnt);
        end
        first_gap = (cnt >= 2) ? ptime[0][n0 + 1] - ptime[0][n0] : -1;
        checks++;
        if (first_gap !== 32) begin
            failures++;
            $display("FAIL hold_first_repeat: gap=%0d expected 32", first_gap);
        end
        bad = (cnt >= 12) ? 0 : 1;
        for (int k = 2; k < 12 && k < cnt; k++) begin
            if (ptime[0][n0 + k] - ptime[0][n0 + k - 1] != 16) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hold_repeat_gaps: bad gaps=%0d expected 0", bad);
        end
    endtask

    task automatic test_rpt_mask();
        int na, nb;
        @(negedge clk);
        na = pcnt[2];
        nb = cnt_b[2];
        btn_raw[2] = 1'b1;
        wait_cycles(200);
        btn_raw[2] = 1'b0;
        wait_cycles(20);
        checks++;
        if (cnt_b[2] - nb !== 1) begin
            failures++;
            $display("FAIL mask_off_count: pulses=%0d expected 1", cnt_b[2] - nb);
        end
        checks++;
        if (pcnt[2] - na !== 12) begin
            failures++;
            $display("FAIL mask_on_count: pulses=%0d expected 12", pcnt[2] - na);
        end
    endtask

    task automatic test_simultaneous();
        int n [NB];
        int t [NB];
        @(negedge clk);
        for (int c = 0; c < NB; c++) n[c] = pcnt[c];
        btn_raw = 3'b111;
        wait_cycles(20);
        btn_raw = 3'b000;
        wait_cycles(20);
        for (int c = 0; c < NB; c++) begin
            checks++;
            if (pcnt[c] - n[c] !== 1) begin
                failures++;
                $display("FAIL simul_count_ch%0d: pulses=%0d expected 1", c, pcnt[c] - n[c]);
            end
            t[c] = (pcnt[c] - n[c] >= 1) ? ptime[c][n[c]] : -1 - c;
        end
        checks++;
        if (t[1] !== t[0] || t[2] !== t[0]) begin
            failures++;
            $display("FAIL simul_align: cycles=%0d,%0d,%0d expected all equal", t[0], t[1], t[2]);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int n0, t0, lat;
        @(negedge clk);
        btn_raw[0] = 1'b1;
        wait_cycles(60);
        checks++;
        if (lvl_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_level: level=%b expected 1", lvl_a[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (lvl_a !== 3'b000 || pulse_a !== 3'b000) begin
            failures++;
            $display("FAIL async_reset: level=%b pulse=%b expected 000/000", lvl_a, pulse_a);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        n0 = pcnt[0];
        t0 = cyc;
        wait_cycles(20);
        btn_raw[0] = 1'b0;
        wait_cycles(20);
        checks++;
        if (pcnt[0] - n0 !== 1) begin
            failures++;
            $display("FAIL post_reset_count: pulses=%0d expected 1", pcnt[0] - n0);
        end
        // Prescaler restarts at 0: ticks end at +4 and +8, so the press lands at +8.
        lat = (pcnt[0] - n0 >= 1) ? ptime[0][n0] - t0 : -1;
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL post_reset_latency: latency=%0d expected 8", lat);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_rpt_mask();
        test_simultaneous();
        test_reset_mid_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adj_button_conditioner.md
# adj_button_conditioner

Input conditioning stage between the top-level `ui_in[2:0]` pins and the clock core's `adj_hrs`/`adj_min`/`adj_sec` inputs. Each raw push-button is synchronised, debounced and converted into single-cycle adjust pulses, with auto-repeat while held. The clock core advances its hour, minute or second field by one per pulse and never sees metastable or bouncing levels.

## Interface
- `NUM_BTN`, 3: number of independent button channels (bit 0 = hours, 1 = minutes, 2 = seconds).
- `TICK_DIV`, 31500: clock cycles per shared tick; must be ≥ 2.
- `DB_TICKS`, 10: consecutive ticks a changed level must persist before it is accepted; must be ≥ 1.
- `RPT_DELAY_TICKS`, 500: ticks from an accepted press to the first repeat pulse; must be ≥ 1.
- `RPT_TICKS`, 150: ticks between subsequent repeat pulses; must be ≥ 1.
- `RPT_MASK`, 3'b111: per-channel auto-repeat enable.

Ports:
- `clk` input 1: single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_raw` input NUM_BTN: asynchronous, active-high button levels.
- `btn_level` output NUM_BTN: debounced level, registered.
- `adj_pulse` output NUM_BTN: one-cycle adjust strobe, registered; drives the core's adjust inputs.

## Operation
- Synchroniser: two flops per channel; `sync` is the second-stage value.
- Prescaler: shared counter 0..TICK_DIV-1. `tick` is high for one cycle when count == TICK_DIV-1, and the counter then wraps to 0.
- Per-channel debounce: counter `db_cnt`.
  - Cleared in any cycle where `sync == btn_level`.
  - Otherwise incremented on `tick`.
  - On a `tick` with `sync != btn_level` and `db_cnt == DB_TICKS-1`: `btn_level` toggles and `db_cnt` clears.
  - Any glitch back to the stable value restarts the count.
- Per-channel FSM:
  - IDLE: `btn_level` = 0. On the rising edge of `btn_level`, assert `adj_pulse`, clear `rpt_cnt`, go to HOLD.
  - HOLD: count ticks in `rpt_cnt`. On the tick where `rpt_cnt == RPT_DELAY_TICKS-1` and `RPT_MASK` bit = 1: pulse, clear `rpt_cnt`, go to REPEAT. If `RPT_MASK` bit = 0, stay in HOLD and never pulse again.
  - REPEAT: on the tick where `rpt_cnt == RPT_TICKS-1`: pulse, clear `rpt_cnt`.
  - Any state: the falling edge of `btn_level` goes to IDLE immediately with no pulse. A repeat pulse due in that same cycle is suppressed.
- Channels are fully independent. Pulses on several channels may coincide, and all are forwarded.
- `rpt_cnt` saturates; it never wraps.

## Timing
- Reset values: all outputs, sync flops, counters = 0; FSM = IDLE.
- Reset asserted mid-hold: outputs drop asynchronously. A button still held at reset release is treated as a fresh press after full sync + debounce.
- Press latency, raw edge to `adj_pulse` (clean edge): 2 cycles (sync) + (DB_TICKS-1)·TICK_DIV + phase, where phase is 1..TICK_DIV. `adj_pulse` rises in the same cycle as `btn_level`.
- Release latency: same formula; no pulse on release.
- `adj_pulse` is high for exactly one cycle per event. Consecutive pulses on one channel are ≥ TICK_DIV cycles apart.
- First repeat: exactly RPT_DELAY_TICKS·TICK_DIV cycles after the press pulse. Subsequent repeats: every RPT_TICKS·TICK_DIV cycles.

## Structure
- Shared package `vga_clock_pkg`: channel index constants (`ADJ_HRS`=0, `ADJ_MIN`=1, `ADJ_SEC`=2), FSM state encoding, and default tick constants, so the core and this block agree.
- One sub-module `adj_btn_channel`: synchroniser, debounce, FSM and repeat counter, taking `tick` as an input. It is instantiated NUM_BTN times by a generate loop.
- The prescaler lives in the top of this block.

## Test plan
Scenarios 1–5 use TICK_DIV=4, DB_TICKS=2, RPT_DELAY_TICKS=8, RPT_TICKS=4.

1. Clean press, `btn_raw[0]` 0→1, held 20 cycles then released → exactly one `adj_pulse[0]`, 2+4+phase cycles after the edge. `btn_level[0]` rises in the same cycle. No pulse on release.
2. Bounce: `btn_raw[1]` toggles every 3 cycles for 30 cycles, then settles at 1 → no pulse during bounce. One pulse 6–10 cycles after settling.
3. Hold 200 cycles on channel 0 → first repeat 32 cycles after the press pulse, then a pulse every 16 cycles. Total pulse count matches the formula.
4. RPT_MASK=3'b011, hold channel 2 for 200 cycles → exactly one pulse.
5. All three buttons pressed in the same cycle → all three pulses in the same cycle.
6. Reset mid-repeat, with channel held, `rst_n` low for 3 cycles → all outputs 0 immediately. After release, a fresh press pulse appears after the full press latency.
